// File: rtl/decoder_if.sv
// Fetch-to-decode-to-ALU pipeline bundle for the RV32I decode stage.
// Handshake: i_ce marks a valid instruction on i_pc/i_instr; while i_stall is high the stage
// accepts nothing and holds every registered output; o_ce marks o_* valid for the ALU stage.
interface decoder_if;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_ce;
  logic        i_stall;
  logic        i_flush;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [31:0] o_pc;
  logic [4:0]  o_rs1_addr_q;
  logic [4:0]  o_rs2_addr_q;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_imm;
  logic [2:0]  o_funct3;
  logic [13:0] o_alu_op;
  logic [10:0] o_opcode;
  logic [3:0]  o_exception;
  logic        o_ce;
  logic        o_stall;
  logic        o_flush;

  modport master (
    output i_pc, i_instr, i_ce, i_stall, i_flush,
    input  o_rs1_addr, o_rs2_addr, o_pc, o_rs1_addr_q, o_rs2_addr_q, o_rd_addr, o_imm,
           o_funct3, o_alu_op, o_opcode, o_exception, o_ce, o_stall, o_flush
  );

  modport slave (
    input  i_pc, i_instr, i_ce, i_stall, i_flush,
    output o_rs1_addr, o_rs2_addr, o_pc, o_rs1_addr_q, o_rs2_addr_q, o_rd_addr, o_imm,
           o_funct3, o_alu_op, o_opcode, o_exception, o_ce, o_stall, o_flush
  );
endinterface

// File: rtl/decoder.sv
// RV32I decode stage: splits the fetched instruction into fields, immediate, one-hot ALU op and
// opcode class, flags illegal/system instructions, and registers the result for the ALU stage.
module decoder (
  input logic      clk,
  input logic      rstn,
  decoder_if.slave bus
);
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5, A_AND = 6;
  localparam int A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11, A_GE = 12, A_GEU = 13;

  localparam int C_RTYPE = 0, C_ITYPE = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4, C_JAL = 5;
  localparam int C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_SYSTEM = 9, C_FENCE = 10;

  logic [31:0] instr;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [10:0] opcode_d;
  logic [13:0] alu_d;
  logic [31:0] imm_d;
  logic [3:0]  exc_d;
  logic        legal;

  assign instr  = bus.i_instr;
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // alt selects SUB/SRA; sub_ok is low for ITYPE where funct7 does not exist for ADDI.
  function automatic logic [13:0] arith_op(input logic [2:0] f3, input logic alt,
                                           input logic sub_ok);
    logic [13:0] r;
    r = '0;
    case (f3)
      3'b000:  r[(alt && sub_ok) ? A_SUB : A_ADD] = 1'b1;
      3'b001:  r[A_SLL]  = 1'b1;
      3'b010:  r[A_SLT]  = 1'b1;
      3'b011:  r[A_SLTU] = 1'b1;
      3'b100:  r[A_XOR]  = 1'b1;
      3'b101:  r[alt ? A_SRA : A_SRL] = 1'b1;
      3'b110:  r[A_OR]   = 1'b1;
      default: r[A_AND]  = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    opcode_d = '0;
    alu_d    = '0;
    imm_d    = '0;
    exc_d    = '0;
    legal    = 1'b0;
    alu_d[A_ADD] = 1'b1;
    case (instr[6:0])
      OPC_RTYPE: begin
        opcode_d[C_RTYPE] = 1'b1;
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        alu_d = arith_op(funct3, funct7[5], 1'b1);
      end
      OPC_ITYPE: begin
        opcode_d[C_ITYPE] = 1'b1;
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
        alu_d = arith_op(funct3, funct7[5], 1'b0);
        imm_d = imm_i;
      end
      OPC_LOAD: begin
        opcode_d[C_LOAD] = 1'b1;
        legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
        imm_d = imm_i;
      end
      OPC_STORE: begin
        opcode_d[C_STORE] = 1'b1;
        legal = (funct3 <= 3'b010);
        imm_d = imm_s;
      end
      OPC_BRANCH: begin
        opcode_d[C_BRANCH] = 1'b1;
        legal = (funct3[2:1] != 2'b01);
        alu_d = '0;
        case (funct3)
          3'b000:  alu_d[A_EQ]   = 1'b1;
          3'b001:  alu_d[A_NEQ]  = 1'b1;
          3'b100:  alu_d[A_SLT]  = 1'b1;
          3'b101:  alu_d[A_GE]   = 1'b1;
          3'b110:  alu_d[A_SLTU] = 1'b1;
          default: alu_d[A_GEU]  = 1'b1;
        endcase
        imm_d = imm_b;
      end
      OPC_JAL: begin
        opcode_d[C_JAL] = 1'b1;
        legal = 1'b1;
        imm_d = imm_j;
      end
      OPC_JALR: begin
        opcode_d[C_JALR] = 1'b1;
        legal = (funct3 == 3'b000);
        imm_d = imm_i;
      end
      OPC_LUI: begin
        opcode_d[C_LUI] = 1'b1;
        legal = 1'b1;
        imm_d = imm_u;
      end
      OPC_AUIPC: begin
        opcode_d[C_AUIPC] = 1'b1;
        legal = 1'b1;
        imm_d = imm_u;
      end
      OPC_SYSTEM: begin
        opcode_d[C_SYSTEM] = 1'b1;
        exc_d[1] = (instr == INSTR_ECALL);
        exc_d[2] = (instr == INSTR_EBREAK);
        exc_d[3] = (instr == INSTR_MRET);
        legal = |exc_d[3:1];
      end
      OPC_FENCE: begin
        opcode_d[C_FENCE] = 1'b1;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal words carry only the illegal flag so nothing downstream acts on stale decode.
    if (!legal) begin
      opcode_d = '0;
      alu_d    = '0;
      imm_d    = '0;
      exc_d    = 4'b0001;
    end
  end

  assign bus.o_rs1_addr = instr[19:15];
  assign bus.o_rs2_addr = instr[24:20];
  assign bus.o_stall    = bus.i_stall & bus.o_ce;
  assign bus.o_flush    = bus.i_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_pc         <= '0;
      bus.o_rs1_addr_q <= '0;
      bus.o_rs2_addr_q <= '0;
      bus.o_rd_addr    <= '0;
      bus.o_imm        <= '0;
      bus.o_funct3     <= '0;
      bus.o_alu_op     <= '0;
      bus.o_opcode     <= '0;
      bus.o_exception  <= '0;
      bus.o_ce         <= 1'b0;
    end else begin
      if (bus.i_ce && !bus.i_stall) begin
        bus.o_pc         <= bus.i_pc;
        bus.o_rs1_addr_q <= instr[19:15];
        bus.o_rs2_addr_q <= instr[24:20];
        bus.o_rd_addr    <= instr[11:7];
        bus.o_imm        <= imm_d;
        bus.o_funct3     <= funct3;
        bus.o_alu_op     <= alu_d;
        bus.o_opcode     <= opcode_d;
        bus.o_exception  <= exc_d;
      end
      // A pending flush survives a stall and squashes on the first free cycle.
      if (!bus.i_stall) bus.o_ce <= bus.i_flush ? 1'b0 : bus.i_ce;
    end
  end
endmodule

// File: tb/tb_decoder.sv
// Bench for the RV32I decode stage: random instruction/control stream against an
// instruction-set-level reference, plus directed cases with hand-computed values.
module tb_decoder;
  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  decoder_if dif ();

  decoder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] op;
    logic [13:0] alu;
    logic [31:0] imm;
    logic [3:0]  exc;
  } dec_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [13:0] alu;
    logic [10:0] op;
    logic [3:0]  exc;
  } exp_t;

  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];
  exp_t          mdl_st;

  // Opcode class k owns bit k of o_opcode.
  logic [6:0] opc_tab [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                               7'h73, 7'h0F};
  int arith_idx [8] = '{0, 7, 2, 3, 4, 8, 5, 6};
  int br_idx    [8] = '{10, 11, 0, 0, 2, 12, 3, 13};

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int cls, alu_idx;
    logic ok;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] s;
    d = '0; cls = -1; alu_idx = 0; ok = 1'b1;
    f3 = w[14:12]; f7 = w[31:25]; s = w;
    for (int k = 0; k < 11; k++) if (w[6:0] == opc_tab[k]) cls = k;
    case (cls)
      0: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        alu_idx = (f7 == 32 && f3 == 0) ? 1 : (f7 == 32 && f3 == 5) ? 9 : arith_idx[f3];
      end
      1: begin
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
        alu_idx = (f3 == 5 && f7[5]) ? 9 : arith_idx[f3];
        d.imm = 32'(s >>> 20);
      end
      2: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; d.imm = 32'(s >>> 20); end
      3: begin ok = (f3 <= 2); d.imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]); end
      4: begin
        ok = !(f3 inside {3'd2, 3'd3});
        alu_idx = br_idx[f3];
        d.imm = 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) |
                (32'(w[11:8]) << 1);
      end
      5: d.imm = 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) |
                 (32'(w[30:21]) << 1);
      6: begin ok = (f3 == 0); d.imm = 32'(s >>> 20); end
      7, 8: d.imm = w & 32'hFFFF_F000;
      9: begin
        ok = (w == 32'h0000_0073) || (w == 32'h0010_0073) || (w == 32'h3020_0073);
        d.exc = {w == 32'h3020_0073, w == 32'h0010_0073, w == 32'h0000_0073, 1'b0};
      end
      10: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d = '0;
      d.exc = 4'b0001;
    end else begin
      d.op  = 11'(1) << cls;
      d.alu = 14'(1) << alu_idx;
    end
    return d;
  endfunction

  function automatic exp_t model_next(input exp_t cur, input logic [31:0] pc, input logic [31:0] w,
                                      input logic ce, input logic stall, input logic flush);
    exp_t n;
    dec_t d;
    n = cur;
    if (ce && !stall) begin
      d = ref_decode(w);
      n.pc = pc; n.rs1 = w[19:15]; n.rs2 = w[24:20]; n.rd = w[11:7]; n.f3 = w[14:12];
      n.imm = d.imm; n.alu = d.alu; n.op = d.op; n.exc = d.exc;
    end
    if (!stall) n.ce = ce && !flush;
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdl_st <= '0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_next(mdl_st, dif.i_pc, dif.i_instr, dif.i_ce, dif.i_stall, dif.i_flush));
      mdl_st <= model_next(mdl_st, dif.i_pc, dif.i_instr, dif.i_ce, dif.i_stall, dif.i_flush);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, all outputs against the reference.
  initial begin
    exp_t e;
    e = '0;
    forever begin
      @(negedge clk);
      if (!rstn) e = '0;
      else if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("ce",      32'(dif.o_ce),         32'(e.ce));
      chk("pc",      dif.o_pc,              e.pc);
      chk("rs1_q",   32'(dif.o_rs1_addr_q), 32'(e.rs1));
      chk("rs2_q",   32'(dif.o_rs2_addr_q), 32'(e.rs2));
      chk("rd",      32'(dif.o_rd_addr),    32'(e.rd));
      chk("imm",     dif.o_imm,             e.imm);
      chk("funct3",  32'(dif.o_funct3),     32'(e.f3));
      chk("alu_op",  32'(dif.o_alu_op),     32'(e.alu));
      chk("opcode",  32'(dif.o_opcode),     32'(e.op));
      chk("exc",     32'(dif.o_exception),  32'(e.exc));
      chk("rs1_cmb", 32'(dif.o_rs1_addr),   32'(dif.i_instr[19:15]));
      chk("rs2_cmb", 32'(dif.o_rs2_addr),   32'(dif.i_instr[24:20]));
      chk("stall",   32'(dif.o_stall),      32'(dif.i_stall & e.ce));
      chk("flush",   32'(dif.o_flush),      32'(dif.i_flush));
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] w, input logic ce,
                       input logic stall, input logic flush);
    dif.i_pc = pc; dif.i_instr = w; dif.i_ce = ce; dif.i_stall = stall; dif.i_flush = flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 9);
    if (sel <= 1) return w;
    if (sel == 2) begin
      case ($urandom_range(0, 3))
        0: return 32'h0000_0073;
        1: return 32'h0010_0073;
        2: return 32'h3020_0073;
        default: return 32'h1050_0073;
      endcase
    end
    w[6:0] = opc_tab[$urandom_range(0, 10)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rstn = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("rst_ce",  32'(dif.o_ce), 32'h0);
    chk("rst_pc",  dif.o_pc, 32'h0);
    chk("rst_op",  32'(dif.o_opcode), 32'h0);
    chk("rst_exc", 32'(dif.o_exception), 32'h0);
    rstn = 1'b1;
    step();

    // addi x1,x2,-5
    drive(32'h100, 32'hFFB1_0093, 1'b1, 1'b0, 1'b0);
    step();
    chk("t1_ce",  32'(dif.o_ce), 32'h1);
    chk("t1_op",  32'(dif.o_opcode), 32'h002);
    chk("t1_alu", 32'(dif.o_alu_op), 32'h0001);
    chk("t1_rd",  32'(dif.o_rd_addr), 32'd1);
    chk("t1_rs1", 32'(dif.o_rs1_addr_q), 32'd2);
    chk("t1_imm", dif.o_imm, 32'hFFFF_FFFB);
    chk("t1_pc",  dif.o_pc, 32'h100);
    chk("t1_exc", 32'(dif.o_exception), 32'h0);

    // beq x1,x2,-8
    drive(32'h104, 32'hFE20_8CE3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("t2_rs1_cmb", 32'(dif.o_rs1_addr), 32'd1);
    step();
    chk("t2_op",  32'(dif.o_opcode), 32'h010);
    chk("t2_alu", 32'(dif.o_alu_op), 32'h0400);
    chk("t2_imm", dif.o_imm, 32'hFFFF_FFF8);
    chk("t2_rs1", 32'(dif.o_rs1_addr_q), 32'd1);
    chk("t2_rs2", 32'(dif.o_rs2_addr_q), 32'd2);

    drive(32'h108, 32'h0000_0000, 1'b1, 1'b0, 1'b0); step();
    chk("t3a_exc", 32'(dif.o_exception), 32'h1);
    chk("t3a_op",  32'(dif.o_opcode), 32'h0);
    drive(32'h10C, 32'h0000_0073, 1'b1, 1'b0, 1'b0); step();
    chk("t3b_exc", 32'(dif.o_exception), 32'h2);
    chk("t3b_op",  32'(dif.o_opcode), 32'h200);
    drive(32'h110, 32'h3020_0073, 1'b1, 1'b0, 1'b0); step();
    chk("t3c_exc", 32'(dif.o_exception), 32'h8);
    chk("t3c_op",  32'(dif.o_opcode), 32'h200);

    // Stall freezes everything; the release cycle's instruction is the one loaded.
    drive(32'h200, 32'hFFB1_0093, 1'b1, 1'b0, 1'b0); step();
    for (int k = 0; k < 3; k++) begin
      drive(32'h210 + 32'(k * 4), rand_instr(), 1'b1, 1'b1, 1'b0);
      step();
      chk("t4_pc",    dif.o_pc, 32'h200);
      chk("t4_ce",    32'(dif.o_ce), 32'h1);
      chk("t4_stall", 32'(dif.o_stall), 32'h1);
    end
    drive(32'h300, 32'hFE20_8CE3, 1'b1, 1'b0, 1'b0); step();
    chk("t4_rel_pc", dif.o_pc, 32'h300);
    chk("t4_rel_op", 32'(dif.o_opcode), 32'h010);

    // Flush squashes; flush under stall waits for the stall to drop.
    drive(32'h400, 32'hFFB1_0093, 1'b1, 1'b0, 1'b1);
    #1;
    chk("t5_flush", 32'(dif.o_flush), 32'h1);
    step();
    chk("t5_ce0", 32'(dif.o_ce), 32'h0);
    drive(32'h404, 32'hFFB1_0093, 1'b1, 1'b0, 1'b0); step();
    chk("t5_ce1", 32'(dif.o_ce), 32'h1);
    drive(32'h408, 32'hFFB1_0093, 1'b1, 1'b1, 1'b1); step();
    chk("t5_hold_a", 32'(dif.o_ce), 32'h1);
    step();
    chk("t5_hold_b", 32'(dif.o_ce), 32'h1);
    drive(32'h40C, 32'hFFB1_0093, 1'b0, 1'b0, 1'b1); step();
    chk("t5_ce_drop", 32'(dif.o_ce), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom & 32'hFFFF_FFFC, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      step();
    end

    // Asynchronous reset in the middle of a cycle.
    drive(32'h500, 32'h3020_0073, 1'b1, 1'b0, 1'b0); step();
    chk("t6_pre_ce", 32'(dif.o_ce), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_ce",  32'(dif.o_ce), 32'h0);
    chk("t6_op",  32'(dif.o_opcode), 32'h0);
    chk("t6_exc", 32'(dif.o_exception), 32'h0);
    chk("t6_pc",  dif.o_pc, 32'h0);
    step();
    step();
    rstn = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
